hinge_loss_batch_ctrl: RTL and testbench

Batch sequencer for the hinge-loss operator. On a start pulse it walks a batch of (prediction, target) pairs out of a local buffer through a single-port read interface. Per element it computes max(0, 1 - pred*tgt) and accumulates the terms, then returns the batch mean plus a margin-violation count over a valid/ready result handshake. It sits between the operator command path and the operand buffer.

---
 rtl/hinge_loss_batch_ctrl_if.sv | 41 ++++
 rtl/hinge_loss_batch_ctrl.sv | 167 ++++++++++++++++
 tb/tb_hinge_loss_batch_ctrl.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/hinge_loss_batch_ctrl_if.sv
// Bus bundle for the hinge-loss batch sequencer: command inputs, operand
// buffer read port and the result handshake.
// The slave modport is the sequencer side; the master modport is the
// command/buffer/consumer side that drives it.
interface hinge_loss_batch_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
);
    // command path
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [4:0]        log2_len;
    logic              abort;

    // operand buffer read port (data returns one cycle after rd_en)
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_pred;
    logic              rd_tgt;

    // status and result handshake
    logic              busy;
    logic              result_valid;
    logic              result_ready;
    logic [DATA_W-1:0] result_loss;
    logic [ADDR_W:0]   result_active;

    modport slave (
        input  start, base_addr, log2_len, abort,
        input  rd_pred, rd_tgt, result_ready,
        output rd_en, rd_addr, busy,
        output result_valid, result_loss, result_active
    );

    modport master (
        output start, base_addr, log2_len, abort,
        output rd_pred, rd_tgt, result_ready,
        input  rd_en, rd_addr, busy,
        input  result_valid, result_loss, result_active
    );
endinterface

// File: rtl/hinge_loss_batch_ctrl.sv
// Hinge-loss batch sequencer.
// Streams 2^log2_len (prediction, target) pairs out of the operand buffer,
// accumulates max(0, ONE - pred*tgt) in Q16.16 and presents the batch mean
// plus the count of margin-violating elements over a valid/ready handshake.
module hinge_loss_batch_ctrl #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    hinge_loss_batch_ctrl_if.slave  bus
);

    // Accumulator wide enough for 2^ADDR_W terms of up to DATA_W+1 bits.
    localparam int ACC_W = DATA_W + 1 + ADDR_W;

    localparam logic [DATA_W-1:0] S_MIN   = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] S_MAX   = {1'b0, {(DATA_W-1){1'b1}}};
    // Q16.16 one, sign-extended to DATA_W+1 bits
    localparam logic [DATA_W:0]   ONE_X   = {{(DATA_W-16){1'b0}}, 1'b1, 16'h0000};
    localparam logic [ADDR_W:0]   LEN_ONE = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [4:0]        LOG2_MAX = 5'(ADDR_W);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state_reg;
    state_t state_next;

    logic [ADDR_W-1:0] addr_reg;      // address of the read issued this cycle
    logic [ADDR_W-1:0] idx_reg;       // element index of the read issued this cycle
    logic [ADDR_W-1:0] last_reg;      // index of the final element (N-1)
    logic [4:0]        shift_reg;     // clamped log2 of the batch length
    logic              ret_valid_reg; // read data on rd_pred/rd_tgt belongs to this batch
    logic [ACC_W-1:0]  acc_reg;
    logic [ADDR_W:0]   active_reg;

    logic [4:0]        log2_clamp;
    logic [ADDR_W:0]   len_full;
    logic [ADDR_W:0]   len_last;
    logic              launch;

    logic [DATA_W-1:0] s_val;
    logic [DATA_W:0]   diff;
    logic              term_pos;
    logic [DATA_W-1:0] term;

    logic [ACC_W-1:0]  acc_shifted;

    // A batch launches only from IDLE, and abort always beats start.
    assign launch     = (state_reg == IDLE) && bus.start && !bus.abort;
    assign log2_clamp = (bus.log2_len > LOG2_MAX) ? LOG2_MAX : bus.log2_len;
    assign len_full   = LEN_ONE << log2_clamp;
    assign len_last   = len_full - LEN_ONE;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state decode and the state-derived handshake outputs.
    always_comb begin
        state_next       = state_reg;
        bus.rd_en        = 1'b0;
        bus.busy         = 1'b1;
        bus.result_valid = 1'b0;
        case (state_reg)
            IDLE: begin
                bus.busy = 1'b0;
                if (launch) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                bus.rd_en = 1'b1;
                if (bus.abort) begin
                    state_next = IDLE;
                end else if (idx_reg == last_reg) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                state_next = bus.abort ? IDLE : DONE;
            end
            DONE: begin
                bus.result_valid = 1'b1;
                if (bus.abort || bus.result_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Per-element term: s = pred * tgt with -MIN saturated, diff = ONE - s.
    always_comb begin
        s_val = bus.rd_pred;
        if (!bus.rd_tgt) begin
            s_val = (bus.rd_pred == S_MIN) ? S_MAX : (~bus.rd_pred + 1'b1);
        end
        diff     = ONE_X - {s_val[DATA_W-1], s_val};
        term_pos = !diff[DATA_W] && (diff != '0);
        // A positive diff never exceeds 2^31 + 2^16, so it fits DATA_W bits unsigned.
        term     = term_pos ? diff[DATA_W-1:0] : '0;
    end

    // Read address walk, batch bookkeeping and accumulation.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_reg      <= '0;
            idx_reg       <= '0;
            last_reg      <= '0;
            shift_reg     <= '0;
            ret_valid_reg <= 1'b0;
            acc_reg       <= '0;
            active_reg    <= '0;
        end else begin
            // Data from a read cut short by abort must not reach the accumulator.
            ret_valid_reg <= (state_reg == FETCH) && !bus.abort;

            if (launch) begin
                addr_reg   <= bus.base_addr;
                idx_reg    <= '0;
                last_reg   <= len_last[ADDR_W-1:0];
                shift_reg  <= log2_clamp;
                acc_reg    <= '0;
                active_reg <= '0;
            end

            if (state_reg == FETCH) begin
                // Address wraps naturally modulo 2^ADDR_W.
                addr_reg <= addr_reg + 1'b1;
                idx_reg  <= idx_reg + 1'b1;
            end

            if (ret_valid_reg && (state_reg != IDLE)) begin
                acc_reg <= acc_reg + {{(ACC_W-DATA_W){1'b0}}, term};
                if (term_pos) begin
                    active_reg <= active_reg + LEN_ONE;
                end
            end
        end
    end

    // Mean = acc / N as a logical shift, saturated to the largest positive Q16.16.
    always_comb begin
        acc_shifted     = acc_reg >> shift_reg;
        bus.result_loss = acc_shifted[DATA_W-1:0];
        if (|acc_shifted[ACC_W-1:DATA_W-1]) begin
            bus.result_loss = S_MAX;
        end
    end

    assign bus.rd_addr       = addr_reg;
    assign bus.result_active = active_reg;

endmodule

// File: tb/tb_hinge_loss_batch_ctrl.sv
// Self-checking bench for hinge_loss_batch_ctrl: directed corner batches,
// abort/reset interruptions and randomized batches against a reference model.
module tb_hinge_loss_batch_ctrl;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1 << ADDR_W;

    logic clk = 1'b0;
    logic rst;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mem_pred [DEPTH];
    logic        mem_tgt  [DEPTH];

    hinge_loss_batch_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    hinge_loss_batch_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Operand buffer: registered read, data valid the cycle after rd_en.
    always @(posedge clk) begin
        if (bus.rd_en) begin
            bus.rd_pred <= mem_pred[bus.rd_addr];
            bus.rd_tgt  <= mem_tgt[bus.rd_addr];
        end
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic over the buffer contents.
    function automatic void ref_model(input int base, input int l2,
                                      output logic [31:0] loss, output logic [10:0] act);
        longint acc = 0;
        longint s;
        longint diff;
        int     ls = (l2 > ADDR_W) ? ADDR_W : l2;
        int     n  = 1 << ls;
        int     cnt = 0;
        for (int i = 0; i < n; i++) begin
            int a = (base + i) % DEPTH;
            s = longint'($signed(mem_pred[a]));
            if (!mem_tgt[a]) begin
                s = (s == -64'sd2147483648) ? 64'sd2147483647 : -s;
            end
            diff = 64'sd65536 - s;
            if (diff > 0) begin
                acc += diff;
                cnt++;
            end
        end
        acc = acc / (64'sd1 << ls);
        loss = (acc > 64'sd2147483647) ? 32'h7FFF_FFFF : 32'(acc);
        act  = 11'(cnt);
    endfunction

    task automatic fill_random(input int base, input int n);
        for (int i = 0; i < n; i++) begin
            int a = (base + i) % DEPTH;
            case ($urandom % 4)
                0:       mem_pred[a] = $urandom;
                1:       mem_pred[a] = 32'h8000_0000;
                default: mem_pred[a] = 32'($urandom_range(0, 32'h0004_0000)) - 32'h0002_0000;
            endcase
            mem_tgt[a] = 1'($urandom % 2);
        end
    endtask

    // Runs one complete batch; entered and left at a falling edge with the DUT idle.
    task automatic run_batch(input int base, input int l2, input int hold, input bit poke);
        logic [31:0] eloss;
        logic [10:0] eact;
        int  n, cyc, reads, first_rd, vcyc, addr_bad;
        bit  seen;
        n = 1 << ((l2 > ADDR_W) ? ADDR_W : l2);
        ref_model(base, l2, eloss, eact);

        bus.start     = 1'b1;
        bus.base_addr = 10'(base);
        bus.log2_len  = 5'(l2);
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 1; reads = 0; first_rd = -1; vcyc = -1; addr_bad = 0; seen = 1'b0;
        while (!seen && cyc < n + 40) begin
            if (bus.rd_en) begin
                if (reads == 0) first_rd = cyc;
                if (int'(bus.rd_addr) != (base + reads) % DEPTH) addr_bad++;
                reads++;
            end
            if (bus.result_valid) begin
                seen = 1'b1;
                vcyc = cyc;
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        check_val("valid_seen", 64'(seen), 64'd1);
        check_val("read_count", 64'(reads), 64'(n));
        check_val("first_read_cycle", 64'(first_rd), 64'd1);
        check_val("valid_cycle", 64'(vcyc), 64'(n + 2));
        check_val("addr_seq_errors", 64'(addr_bad), 64'd0);
        check_val("result_loss", 64'(bus.result_loss), 64'(eloss));
        check_val("result_active", 64'(bus.result_active), 64'(eact));
        $display("batch base=0x%03h log2_len=%0d reads=%0d loss=0x%08h active=%0d expected loss=0x%08h active=%0d",
                 base, l2, reads, bus.result_loss, bus.result_active, eloss, eact);

        for (int h = 0; h < hold; h++) begin
            bus.start     = poke && (h == 1);
            bus.base_addr = 10'($urandom);
            bus.log2_len  = 5'($urandom % 4);
            @(negedge clk);
            check_val("hold_loss", 64'(bus.result_loss), 64'(eloss));
            check_val("hold_active", 64'(bus.result_active), 64'(eact));
            check_val("hold_valid", 64'(bus.result_valid), 64'd1);
            check_val("hold_busy", 64'(bus.busy), 64'd1);
            check_val("hold_rd_en", 64'(bus.rd_en), 64'd0);
        end
        bus.start        = 1'b0;
        bus.result_ready = 1'b1;
        @(negedge clk);
        bus.result_ready = 1'b0;
        check_val("post_valid", 64'(bus.result_valid), 64'd0);
        check_val("post_busy", 64'(bus.busy), 64'd0);
        check_val("post_rd_en", 64'(bus.rd_en), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_rd_en"}, 64'(bus.rd_en), 64'd0);
        check_val({tag, "_rd_addr"}, 64'(bus.rd_addr), 64'd0);
        check_val({tag, "_busy"}, 64'(bus.busy), 64'd0);
        check_val({tag, "_valid"}, 64'(bus.result_valid), 64'd0);
        check_val({tag, "_loss"}, 64'(bus.result_loss), 64'd0);
        check_val({tag, "_active"}, 64'(bus.result_active), 64'd0);
    endtask

    initial begin
        int stray;
        rst = 1'b1;
        bus.start = 1'b0; bus.base_addr = '0; bus.log2_len = '0;
        bus.abort = 1'b0; bus.result_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            mem_pred[i] = '0;
            mem_tgt[i]  = 1'b1;
        end
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // Mixed-sign directed batch: terms 0, 0x8000, 0x20000, 0.
        mem_pred[0] = 32'h0002_0000; mem_tgt[0] = 1'b1;
        mem_pred[1] = 32'h0000_8000; mem_tgt[1] = 1'b1;
        mem_pred[2] = 32'h0001_0000; mem_tgt[2] = 1'b0;
        mem_pred[3] = 32'hFFFF_0000; mem_tgt[3] = 1'b0;
        run_batch(0, 2, 0, 1'b0);
        check_val("directed_loss_const", 64'(bus.result_loss), 64'h0000_A000);

        // Single element at the most negative prediction, both target signs.
        mem_pred[5] = 32'h8000_0000; mem_tgt[5] = 1'b1;
        run_batch(5, 0, 0, 1'b0);
        mem_tgt[5] = 1'b0;
        run_batch(5, 0, 0, 1'b0);

        // Address wrap and length clamp.
        fill_random(32'h3FE, 4);
        run_batch(32'h3FE, 2, 1, 1'b0);
        fill_random(0, DEPTH);
        run_batch(32'h155, 12, 0, 1'b0);

        // Result held in DONE with a stray start pulse.
        fill_random(32'h100, 8);
        run_batch(32'h100, 3, 5, 1'b1);

        // Abort during FETCH after the third read.
        fill_random(32'h200, 8);
        bus.start = 1'b1; bus.base_addr = 10'h200; bus.log2_len = 5'd3;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        check_val("abort_third_read", 64'(bus.rd_en), 64'd1);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check_val("abort_rd_en", 64'(bus.rd_en), 64'd0);
        check_val("abort_busy", 64'(bus.busy), 64'd0);
        stray = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.result_valid || bus.rd_en || bus.busy) stray++;
        end
        check_val("abort_no_result", 64'(stray), 64'd0);
        for (int i = 0; i < 8; i++) begin
            mem_pred[(32'h300 + i) % DEPTH] = '0;
            mem_tgt[(32'h300 + i) % DEPTH]  = 1'b1;
        end
        run_batch(32'h300, 3, 0, 1'b0);
        check_val("zero_batch_loss_const", 64'(bus.result_loss), 64'h0001_0000);
        check_val("zero_batch_active_const", 64'(bus.result_active), 64'd8);

        // Reset mid-FETCH, then start and abort together.
        fill_random(32'h040, 16);
        bus.start = 1'b1; bus.base_addr = 10'h040; bus.log2_len = 5'd4;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("midrst");
        bus.start = 1'b1; bus.abort = 1'b1; bus.base_addr = 10'h010; bus.log2_len = 5'd2;
        @(negedge clk);
        bus.start = 1'b0; bus.abort = 1'b0;
        stray = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus.rd_en || bus.busy || bus.result_valid) stray++;
            @(negedge clk);
        end
        check_val("start_abort_idle", 64'(stray), 64'd0);

        // Randomized batches.
        for (int t = 0; t < 24; t++) begin
            int base = int'($urandom % DEPTH);
            int l2   = ($urandom % 8 == 0) ? 15 : int'($urandom % 7);
            fill_random(base, 1 << ((l2 > ADDR_W) ? ADDR_W : l2));
            run_batch(base, l2, int'($urandom % 4), 1'($urandom % 2));
        end

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
